memshare_cfg_loader: RTL and testbench
======================================

MEMSHARE_CFG_LOADER -- requirements
Module: memshare_cfg_loader

Interface
REQ-001 SHALL have parameter TYPE0_ADDR_BITWIDTH, default 6, regFile page address width.
REQ-002 SHALL have parameter TYPE0_REG_BITWIDTH, default 7, regFile page data width.
REQ-003 SHALL have parameter TYPE0_PAGE_NUM, default 64, number of regFile pages; address wrap modulus.
REQ-004 SHALL have parameter FLUSH_CYCLES, default 2, delta-pipe flush length (>=1).
REQ-005 SHALL have ports: sys_clk input 1, sole clock; rst input 1, reset. One clock; reset synchronous, active-high.
REQ-006 SHALL have ports: cfg_start_i in 1, load-start pulse; cfg_base_i in TYPE0_ADDR_BITWIDTH, first page; cfg_len_i in TYPE0_ADDR_BITWIDTH+1, word count (0..TYPE0_PAGE_NUM).
REQ-007 SHALL have ports: cfg_valid_i in 1, cfg_data_i in TYPE0_REG_BITWIDTH, cfg_ready_o out 1; this is the word-stream handshake.
REQ-008 SHALL have ports: cfg_abort_i in 1, abandon the load.
REQ-009 SHALL have ports: regType0_waddr_o out TYPE0_ADDR_BITWIDTH, regType0_wdata_o out TYPE0_REG_BITWIDTH, regType0_we_o out 1; these are the regFile write port.
REQ-010 SHALL have ports: deltaPipe_rstn_o out 1, active-low delta-pipe flush; stall_o out 1, hold rfmu/datapath; done_o out 1, completion pulse; err_o out 1, sticky error.

Function
REQ-011 SHALL implement FSM IDLE -> LOAD -> FLUSH -> DONE -> IDLE.
REQ-012 IDLE: cfg_start_i SHALL latch base and len; len=0 goes to FLUSH, otherwise to LOAD.
REQ-013 cfg_start_i SHALL be ignored outside IDLE.
REQ-014 cfg_ready_o SHALL be 1 only in LOAD.
REQ-015 A word SHALL be accepted on cfg_valid_i && cfg_ready_o.
REQ-016 An accepted word SHALL appear on the write port the next cycle: we=1 for exactly 1 cycle, waddr = (base + index) mod TYPE0_PAGE_NUM, wdata = accepted word.
REQ-017 The last word accepted in LOAD SHALL take the FSM to FLUSH at the same edge; ready SHALL drop in the following cycle.
REQ-018 cfg_abort_i in LOAD SHALL take precedence over a same-cycle accept: no write issues, err_o is set, and the FSM goes to FLUSH.
REQ-019 cfg_abort_i SHALL be ignored in other states.
REQ-020 FLUSH SHALL drive deltaPipe_rstn_o=0 for exactly FLUSH_CYCLES cycles, then go to DONE.
REQ-021 DONE SHALL pulse done_o for 1 cycle, then return to IDLE.
REQ-022 stall_o SHALL be 1 in LOAD, FLUSH and DONE, and 0 in IDLE.
REQ-023 err_o SHALL be sticky and clear only on rst or on an accepted cfg_start_i.
REQ-024 Arithmetic SHALL be done in TYPE0_ADDR_BITWIDTH+1 bits internally; addresses wrap, e.g. 63 -> 0 at 64 pages.

Reset
REQ-025 On rst=1 at a clock edge the FSM SHALL go to IDLE, counters SHALL clear, and in-flight writes SHALL be dropped.
REQ-026 Outputs after reset SHALL be: cfg_ready_o=0, regType0_we_o=0, waddr=0, wdata=0, deltaPipe_rstn_o=1, stall_o=0, done_o=0, err_o=0.
REQ-027 rst mid-LOAD SHALL suppress any pending write on the next cycle.

Configuration
REQ-028 Macro MEMSHARE_CFG_PARITY_EN, when defined, SHALL add input cfg_par_i (1 bit, even parity over cfg_data_i) sampled on each accept.
REQ-029 With MEMSHARE_CFG_PARITY_EN, a mismatching word SHALL not be written, err_o SHALL be set, and the load SHALL continue with the address index still advancing.
REQ-030 Without MEMSHARE_CFG_PARITY_EN, the block SHALL have no cfg_par_i port, perform no check, and err_o SHALL be set by abort only.

Structure
REQ-031 Package memshare_cfg_pkg SHALL hold the FSM state enum (IDLE, LOAD, FLUSH, DONE) and default width/page constants shared with the regFile wrapper.
REQ-032 There SHALL be one sub-module, memshare_cfg_parity (combinational parity check), instantiated only under MEMSHARE_CFG_PARITY_EN.

Verification (cycle 0 = start edge)
REQ-033 Bench SHALL drive start at cycle 0 with base=62, len=3, valid held high, FLUSH_CYCLES=2, and check: ready=1 in cycles 1-3; we in cycles 2-4 with addr 62, 63, 0; deltaPipe_rstn_o=0 in cycles 4-5; done_o in cycle 6; stall_o=1 in cycles 1-6.
REQ-034 Bench SHALL start with len=0 and check: no we, ready never 1, deltaPipe_rstn_o low in cycles 1-2, done_o in cycle 3.
REQ-035 Bench SHALL assert abort together with valid on the 2nd word of len=4 and check: only 1 write, err_o=1, then FLUSH followed by done_o.
REQ-036 Bench SHALL toggle valid 1,0,1,0 with len=2 and check the writes are spaced by the stall; a second cfg_start_i during LOAD is ignored and base is unchanged.
REQ-037 Bench SHALL assert rst in the cycle after the 1st accept and check: no we next cycle, all outputs at reset values.
REQ-038 With MEMSHARE_CFG_PARITY_EN, bench SHALL send data 7'h03 with cfg_par_i=1 and check: that word is not written, err_o=1, and the next word is written at base+1.

Source files
------------

// File: rtl/memshare_cfg_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | memshare_cfg_pkg                                                      |
// | FSM states and default regFile geometry shared with the regFile wrap. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package memshare_cfg_pkg;

  localparam int c_TYPE0_ADDR_BITWIDTH = 6;
  localparam int c_TYPE0_REG_BITWIDTH  = 7;
  localparam int c_TYPE0_PAGE_NUM      = 64;
  localparam int c_FLUSH_CYCLES        = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } cfg_state_e;

endpackage
`default_nettype wire

// File: rtl/memshare_cfg_parity.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | memshare_cfg_parity                                                   |
// | Even-parity check of one configuration word against its parity bit.   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module memshare_cfg_parity
  import memshare_cfg_pkg::*;
#(
  parameter int DATA_W = c_TYPE0_REG_BITWIDTH
) (
  input  logic [DATA_W-1:0] i_data,
  input  logic              i_par,
  output logic              o_par_ok
);

  // Even parity: data bits plus parity bit carry an even number of ones.
  assign o_par_ok = ((^i_data) == i_par);

endmodule
`default_nettype wire

// File: rtl/memshare_cfg_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | memshare_cfg_loader                                                   |
// | Streams config words into regFile pages, then flushes the delta pipe. |
// | Option macro: MEMSHARE_CFG_PARITY_EN (adds cfg_par_i word check).     |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module memshare_cfg_loader
  import memshare_cfg_pkg::*;
#(
  parameter int TYPE0_ADDR_BITWIDTH = c_TYPE0_ADDR_BITWIDTH,
  parameter int TYPE0_REG_BITWIDTH  = c_TYPE0_REG_BITWIDTH,
  parameter int TYPE0_PAGE_NUM      = c_TYPE0_PAGE_NUM,
  parameter int FLUSH_CYCLES        = c_FLUSH_CYCLES
) (
  input  logic                           sys_clk,
  input  logic                           rst,
  input  logic                           cfg_start_i,
  input  logic [TYPE0_ADDR_BITWIDTH-1:0] cfg_base_i,
  input  logic [TYPE0_ADDR_BITWIDTH:0]   cfg_len_i,
  input  logic                           cfg_valid_i,
  input  logic [TYPE0_REG_BITWIDTH-1:0]  cfg_data_i,
`ifdef MEMSHARE_CFG_PARITY_EN
  input  logic                           cfg_par_i,
`endif
  output logic                           cfg_ready_o,
  input  logic                           cfg_abort_i,
  output logic [TYPE0_ADDR_BITWIDTH-1:0] regType0_waddr_o,
  output logic [TYPE0_REG_BITWIDTH-1:0]  regType0_wdata_o,
  output logic                           regType0_we_o,
  output logic                           deltaPipe_rstn_o,
  output logic                           stall_o,
  output logic                           done_o,
  output logic                           err_o
);

  localparam int c_CNT_W   = TYPE0_ADDR_BITWIDTH + 1;
  localparam int c_FLUSH_W = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  localparam logic [c_CNT_W-1:0]   c_PAGE_NUM   = c_CNT_W'(TYPE0_PAGE_NUM);
  localparam logic [c_CNT_W-1:0]   c_CNT_ONE    = c_CNT_W'(1);
  localparam logic [c_FLUSH_W-1:0] c_FLUSH_LAST = c_FLUSH_W'(FLUSH_CYCLES - 1);
  localparam logic [c_FLUSH_W-1:0] c_FLUSH_ONE  = c_FLUSH_W'(1);

  cfg_state_e r_state;
  cfg_state_e w_state_nxt;

  logic [TYPE0_ADDR_BITWIDTH-1:0] r_base;
  logic [c_CNT_W-1:0]             r_len;
  logic [c_CNT_W-1:0]             r_idx;
  logic [c_FLUSH_W-1:0]           r_flush_cnt;
  logic                           r_we;
  logic [TYPE0_ADDR_BITWIDTH-1:0] r_waddr;
  logic [TYPE0_REG_BITWIDTH-1:0]  r_wdata;
  logic                           r_err;

  logic w_ready, w_stall, w_done, w_flush_n;
  logic w_start, w_abort, w_take, w_last, w_write, w_par_ok, w_par_err, w_flush_last;
  logic [c_CNT_W-1:0]             w_sum;
  logic [TYPE0_ADDR_BITWIDTH-1:0] w_addr;

  assign w_start      = (r_state == IDLE) && cfg_start_i;
  assign w_abort      = (r_state == LOAD) && cfg_abort_i;
  // Abort wins over a same-cycle handshake.
  assign w_take       = cfg_valid_i && w_ready && !w_abort;
  assign w_last       = w_take && ((r_idx + c_CNT_ONE) == r_len);
  assign w_write      = w_take && w_par_ok;
  assign w_par_err    = w_take && !w_par_ok;
  assign w_flush_last = (r_flush_cnt == c_FLUSH_LAST);

  // base + index never exceeds two page spans, so one conditional subtract wraps it.
  assign w_sum  = {1'b0, r_base} + r_idx;
  assign w_addr = TYPE0_ADDR_BITWIDTH'((w_sum >= c_PAGE_NUM) ? (w_sum - c_PAGE_NUM) : w_sum);

`ifdef MEMSHARE_CFG_PARITY_EN
  memshare_cfg_parity #(
    .DATA_W (TYPE0_REG_BITWIDTH)
  ) u_parity (
    .i_data   (cfg_data_i),
    .i_par    (cfg_par_i),
    .o_par_ok (w_par_ok)
  );
`else
  assign w_par_ok = 1'b1;
`endif

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_start) w_state_nxt = (cfg_len_i == '0) ? FLUSH : LOAD;
      LOAD:    if (w_abort || w_last) w_state_nxt = FLUSH;
      FLUSH:   if (w_flush_last) w_state_nxt = DONE;
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    w_ready   = 1'b0;
    w_stall   = 1'b1;
    w_done    = 1'b0;
    w_flush_n = 1'b1;
    case (r_state)
      IDLE:    w_stall   = 1'b0;
      LOAD:    w_ready   = 1'b1;
      FLUSH:   w_flush_n = 1'b0;
      DONE:    w_done    = 1'b1;
      default: w_stall   = 1'b0;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      r_base      <= '0;
      r_len       <= '0;
      r_idx       <= '0;
      r_flush_cnt <= '0;
      r_we        <= 1'b0;
      r_waddr     <= '0;
      r_wdata     <= '0;
      r_err       <= 1'b0;
    end else begin
      r_we <= w_write;
      if (w_write) begin
        r_waddr <= w_addr;
        r_wdata <= cfg_data_i;
      end

      if (w_start) begin
        r_base <= cfg_base_i;
        r_len  <= cfg_len_i;
        r_idx  <= '0;
      end else if (w_take) begin
        r_idx <= r_idx + c_CNT_ONE;
      end

      if (r_state == FLUSH) begin
        r_flush_cnt <= r_flush_cnt + c_FLUSH_ONE;
      end else begin
        r_flush_cnt <= '0;
      end

      if (w_start) begin
        r_err <= 1'b0;
      end else if (w_abort || w_par_err) begin
        r_err <= 1'b1;
      end
    end
  end

  assign cfg_ready_o      = w_ready;
  assign stall_o          = w_stall;
  assign done_o           = w_done;
  assign deltaPipe_rstn_o = w_flush_n;
  assign regType0_we_o    = r_we;
  assign regType0_waddr_o = r_waddr;
  assign regType0_wdata_o = r_wdata;
  assign err_o            = r_err;

endmodule
`default_nettype wire

// File: tb/tb_memshare_cfg_loader.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_memshare_cfg_loader                                                |
// | Random and directed loads checked against a transaction-level model. |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_memshare_cfg_loader;

  localparam int AW    = 6;
  localparam int LW    = AW + 1;
  localparam int DW    = 7;
  localparam int PAGES = 64;
  localparam int FLUSH = 2;

  logic          sys_clk = 1'b0;
  logic          rst;
  logic          cfg_start_i;
  logic [AW-1:0] cfg_base_i;
  logic [LW-1:0] cfg_len_i;
  logic          cfg_valid_i;
  logic [DW-1:0] cfg_data_i;
  logic          cfg_ready_o;
  logic          cfg_abort_i;
  logic [AW-1:0] regType0_waddr_o;
  logic [DW-1:0] regType0_wdata_o;
  logic          regType0_we_o;
  logic          deltaPipe_rstn_o;
  logic          stall_o;
  logic          done_o;
  logic          err_o;
`ifdef MEMSHARE_CFG_PARITY_EN
  logic          cfg_par_i;
`endif

  memshare_cfg_loader #(
    .TYPE0_ADDR_BITWIDTH (AW),
    .TYPE0_REG_BITWIDTH  (DW),
    .TYPE0_PAGE_NUM      (PAGES),
    .FLUSH_CYCLES        (FLUSH)
  ) dut (
    .sys_clk          (sys_clk),
    .rst              (rst),
    .cfg_start_i      (cfg_start_i),
    .cfg_base_i       (cfg_base_i),
    .cfg_len_i        (cfg_len_i),
    .cfg_valid_i      (cfg_valid_i),
    .cfg_data_i       (cfg_data_i),
`ifdef MEMSHARE_CFG_PARITY_EN
    .cfg_par_i        (cfg_par_i),
`endif
    .cfg_ready_o      (cfg_ready_o),
    .cfg_abort_i      (cfg_abort_i),
    .regType0_waddr_o (regType0_waddr_o),
    .regType0_wdata_o (regType0_wdata_o),
    .regType0_we_o    (regType0_we_o),
    .deltaPipe_rstn_o (deltaPipe_rstn_o),
    .stall_o          (stall_o),
    .done_o           (done_o),
    .err_o            (err_o)
  );

  always #5 sys_clk = ~sys_clk;

  int vectors     = 0;
  int miscompares = 0;
  int cyc         = 0;
  bit exp_err     = 1'b0;

  typedef struct {
    int addr;
    int data;
    int due;
  } wr_t;

  wr_t exp_q[$];
  wr_t mon_e;

  always @(posedge sys_clk) cyc++;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Scoreboard: every DUT write must match the oldest predicted write, on its cycle.
  always @(negedge sys_clk) begin
    if (regType0_we_o !== 1'b0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", 32'(regType0_we_o), 32'(0));
      end else begin
        mon_e = exp_q.pop_front();
        check("waddr", 32'(regType0_waddr_o), 32'(mon_e.addr));
        check("wdata", 32'(regType0_wdata_o), 32'(mon_e.data));
        check("we_cycle", 32'(cyc), 32'(mon_e.due));
      end
    end
  end

  task automatic next_cycle();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic at_sample();
    @(negedge sys_clk);
  endtask

  // One complete load: start, stream words, flush, done, one idle cycle.
  // vmode: valid probability in percent, or -1 for a 1,0,1,0 pattern.
  task automatic run_load(input int base, input int len, input int vmode,
                          input int abort_idx, input bit extra_start, input int bad_idx);
    int k;
    int a;
    int guard;
    bit v;
    bit ab;
    bit bad;
    bit stop;
    k = 0; a = 0; guard = 0; stop = 1'b0;

    cfg_start_i = 1'b1;
    cfg_base_i  = AW'(base);
    cfg_len_i   = LW'(len);
    cfg_valid_i = 1'($urandom);
    cfg_abort_i = 1'($urandom);
    cfg_data_i  = DW'($urandom);
    at_sample();
    check("idle_ready", 32'(cfg_ready_o), 32'(0));
    check("idle_stall", 32'(stall_o), 32'(0));
    check("err_sticky", 32'(err_o), 32'(exp_err));
    exp_err = 1'b0;
    next_cycle();
    cfg_start_i = 1'b0;

    while (k < len && !stop) begin
      v = (vmode < 0) ? (a % 2 == 0) : ($urandom_range(99) < vmode);
      a++;
      ab  = v && (k == abort_idx);
      bad = 1'b0;
      cfg_valid_i = v;
      cfg_abort_i = ab;
      cfg_data_i  = DW'($urandom);
`ifdef MEMSHARE_CFG_PARITY_EN
      if (k == bad_idx) begin
        cfg_data_i = 7'h03;
        cfg_par_i  = 1'b1;
        bad        = v;
      end else begin
        cfg_par_i = ^cfg_data_i;
      end
`endif
      cfg_start_i = extra_start && (a == 2);
      cfg_base_i  = AW'($urandom);
      cfg_len_i   = LW'($urandom_range(PAGES));
      at_sample();
      check("load_ready", 32'(cfg_ready_o), 32'(1));
      check("load_stall", 32'(stall_o), 32'(1));
      check("load_rstn", 32'(deltaPipe_rstn_o), 32'(1));
      check("load_done", 32'(done_o), 32'(0));
      check("load_err", 32'(err_o), 32'(exp_err));
      if (ab) begin
        stop    = 1'b1;
        exp_err = 1'b1;
      end else if (v) begin
        if (bad) exp_err = 1'b1;
        else exp_q.push_back('{addr: (base + k) % PAGES, data: int'(cfg_data_i), due: cyc + 1});
        k++;
      end
      guard++;
      if (guard > 2000) begin
        check("load_timeout", 32'(guard), 32'(0));
        stop = 1'b1;
      end
      next_cycle();
    end

    cfg_start_i = 1'b0;
    for (int i = 0; i < FLUSH; i++) begin
      cfg_valid_i = 1'($urandom);
      cfg_abort_i = 1'($urandom);
      at_sample();
      check("flush_ready", 32'(cfg_ready_o), 32'(0));
      check("flush_rstn", 32'(deltaPipe_rstn_o), 32'(0));
      check("flush_stall", 32'(stall_o), 32'(1));
      check("flush_done", 32'(done_o), 32'(0));
      check("flush_err", 32'(err_o), 32'(exp_err));
      next_cycle();
    end

    at_sample();
    check("done_pulse", 32'(done_o), 32'(1));
    check("done_stall", 32'(stall_o), 32'(1));
    check("done_rstn", 32'(deltaPipe_rstn_o), 32'(1));
    next_cycle();
    cfg_valid_i = 1'b0;
    cfg_abort_i = 1'b0;
    at_sample();
    check("after_done", 32'(done_o), 32'(0));
    check("after_stall", 32'(stall_o), 32'(0));
    check("after_err", 32'(err_o), 32'(exp_err));
    check("writes_drained", 32'(exp_q.size()), 32'(0));
    next_cycle();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ready"}, 32'(cfg_ready_o), 32'(0));
    check({tag, "_we"}, 32'(regType0_we_o), 32'(0));
    check({tag, "_waddr"}, 32'(regType0_waddr_o), 32'(0));
    check({tag, "_wdata"}, 32'(regType0_wdata_o), 32'(0));
    check({tag, "_rstn"}, 32'(deltaPipe_rstn_o), 32'(1));
    check({tag, "_stall"}, 32'(stall_o), 32'(0));
    check({tag, "_done"}, 32'(done_o), 32'(0));
    check({tag, "_err"}, 32'(err_o), 32'(0));
  endtask

  // Reset lands on the edge that would accept the second word.
  task automatic run_reset_mid_load();
    cfg_start_i = 1'b1;
    cfg_base_i  = AW'(5);
    cfg_len_i   = LW'(4);
    cfg_valid_i = 1'b0;
    at_sample();
    exp_err = 1'b0;
    next_cycle();
    cfg_start_i = 1'b0;
    cfg_valid_i = 1'b1;
    cfg_data_i  = DW'($urandom);
`ifdef MEMSHARE_CFG_PARITY_EN
    cfg_par_i = ^cfg_data_i;
`endif
    at_sample();
    check("rstmid_ready", 32'(cfg_ready_o), 32'(1));
    exp_q.push_back('{addr: 5, data: int'(cfg_data_i), due: cyc + 1});
    next_cycle();
    rst        = 1'b1;
    cfg_data_i = DW'($urandom);
`ifdef MEMSHARE_CFG_PARITY_EN
    cfg_par_i = ^cfg_data_i;
`endif
    next_cycle();
    rst         = 1'b0;
    cfg_valid_i = 1'b0;
    at_sample();
    check_reset_outputs("rstmid");
    check("rstmid_drained", 32'(exp_q.size()), 32'(0));
    next_cycle();
  endtask

  initial begin
    int base;
    int len;
    int ab_idx;
    int bad_idx;
    rst         = 1'b1;
    cfg_start_i = 1'b0;
    cfg_base_i  = '0;
    cfg_len_i   = '0;
    cfg_valid_i = 1'b0;
    cfg_data_i  = '0;
    cfg_abort_i = 1'b0;
`ifdef MEMSHARE_CFG_PARITY_EN
    cfg_par_i = 1'b0;
`endif
    repeat (3) @(posedge sys_clk);
    #1;
    rst = 1'b0;
    at_sample();
    check_reset_outputs("reset");
    next_cycle();

    run_load(62, 3, 100, -1, 1'b0, -1);
    run_load(17, 0, 100, -1, 1'b0, -1);
    run_load(20, 4, 100, 1, 1'b0, -1);
    run_load(40, 2, -1, -1, 1'b1, -1);
    run_reset_mid_load();
`ifdef MEMSHARE_CFG_PARITY_EN
    run_load(10, 3, 100, -1, 1'b0, 0);
`endif

    for (int n = 0; n < 40; n++) begin
      base    = int'($urandom_range(PAGES - 1));
      len     = ($urandom_range(3) == 0) ? int'($urandom_range(PAGES)) : int'($urandom_range(8));
      ab_idx  = ($urandom_range(4) == 0 && len > 0) ? int'($urandom_range(len - 1)) : -1;
      bad_idx = ($urandom_range(3) == 0 && len > 0) ? int'($urandom_range(len - 1)) : -1;
      run_load(base, len, int'($urandom_range(100, 30)), ab_idx, 1'($urandom), bad_idx);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: run did not complete (cycle %0d)", cyc);
    $fatal(1);
  end

endmodule
`default_nettype wire
